algofoogle_tracer_driver: RTL and testbench

//  Host-side sequencer for the nibble-serial reciprocal tracer. Accepts a 16-bit
//  Q6.10 operand over a valid/ready handshake, streams it MSN-first as 4 nibbles
//  in lockstep with the tracer's free-running 6-step frame, and captures the two

---
 rtl/algofoogle_tracer_driver.sv | 100 ++++++++++
 tb/tb_algofoogle_tracer_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/algofoogle_tracer_driver.sv
// algofoogle_tracer_driver: streams Q6.10 operands to the nibble-serial tracer in lockstep
// with its 6-step frame and queues the returned reciprocals in a 2-entry result FIFO.
module algofoogle_tracer_driver #(
    parameter int SYNC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [15:0] i_operand,
    input  logic        i_abs,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [15:0] o_result,
    output logic        o_tracer_reset,
    output logic        o_tracer_abs,
    output logic [3:0]  o_tracer_nibble,
    input  logic [7:0]  i_tracer_byte
);
    localparam int CW = $clog2(SYNC_CYCLES + 1);

    typedef enum logic {SYNC, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    phase_q, phase_d;
    logic [15:0]   op_q, head_q, tail_q;
    logic [7:0]    hi_q;
    logic [1:0]    count_q;
    logic          cur_abs_q, prev_abs_q, flight_q, land_q;
    logic          run, p5, accept, push, pop;
    logic [15:0]   din;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        phase_d         = 3'd0;
        run             = state_q == RUN;
        p5              = run && phase_q == 3'd5;
        if (!run) begin
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(SYNC_CYCLES - 1)) ? RUN : SYNC;
        end else begin
            phase_d = p5 ? 3'd0 : phase_q + 3'd1;
        end
        // a frame still in flight reserves a FIFO slot; pops in this cycle earn no credit
        o_op_ready      = p5 && (count_q + {1'b0, flight_q}) < 2'd2;
        accept          = i_op_valid && o_op_ready;
        push            = run && phase_q == 3'd0 && land_q;
        pop             = i_res_ready && count_q != 2'd0;
        din             = {hi_q, i_tracer_byte};
        o_res_valid     = count_q != 2'd0;
        o_result        = head_q;
        o_tracer_reset  = !run;
        // phase 0 still belongs to the previous frame's low-byte readout
        o_tracer_abs    = run && (phase_q == 3'd0 ? prev_abs_q : cur_abs_q);
        o_tracer_nibble = phase_q == 3'd0 ? op_q[15:12] :
                          phase_q == 3'd1 ? op_q[11:8]  :
                          phase_q == 3'd2 ? op_q[7:4]   :
                          phase_q == 3'd3 ? op_q[3:0]   : 4'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            phase_q    <= 3'd0;
            op_q       <= 16'h0;
            cur_abs_q  <= 1'b0;
            prev_abs_q <= 1'b0;
            flight_q   <= 1'b0;
            land_q     <= 1'b0;
            hi_q       <= 8'h0;
            head_q     <= 16'h0;
            tail_q     <= 16'h0;
            count_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (p5) begin
                op_q       <= accept ? i_operand : 16'h0;
                cur_abs_q  <= accept && i_abs;
                prev_abs_q <= cur_abs_q;
                flight_q   <= accept;
                land_q     <= flight_q;
                hi_q       <= i_tracer_byte;
            end
            if (push)
                land_q <= 1'b0;
            if (pop && count_q == 2'd2)
                head_q <= tail_q;
            else if (push && (count_q == 2'd0 || (pop && count_q == 2'd1)))
                head_q <= din;
            if (push && (count_q == 2'd2 || (count_q == 2'd1 && !pop)))
                tail_q <= din;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_algofoogle_tracer_driver.sv
// tb_algofoogle_tracer_driver: directed checks of the tracer driver against a behavioural
// tracer that computes signed Q6.10 reciprocals from the nibbles it receives.
module tb_algofoogle_tracer_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic [15:0] i_operand = 16'h0;
    logic        i_abs = 1'b0;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [15:0] o_result;
    logic        o_tracer_reset;
    logic        o_tracer_abs;
    logic [3:0]  o_tracer_nibble;
    logic [7:0]  i_tracer_byte;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    algofoogle_tracer_driver #(.SYNC_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
        .i_operand(i_operand), .i_abs(i_abs),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_result(o_result),
        .o_tracer_reset(o_tracer_reset), .o_tracer_abs(o_tracer_abs),
        .o_tracer_nibble(o_tracer_nibble), .i_tracer_byte(i_tracer_byte)
    );

    // behavioural tracer: free-running 6-step frame, synchronous reset
    logic [2:0]  t_step = 3'd0;
    logic [15:0] t_sh = 16'h0;
    logic [15:0] t_op = 16'h0;
    logic [15:0] t_res;

    function automatic logic [15:0] recip(input logic [15:0] x, input logic a);
        logic signed [31:0] v;
        v = $signed({{16{x[15]}}, x});
        if (a && v < 0) v = -v;
        return (v == 0) ? 16'h7fff : 16'(32'sd1048576 / v);
    endfunction

    always @(posedge clk) begin
        t_step <= o_tracer_reset ? 3'd0 : (t_step == 3'd5 ? 3'd0 : t_step + 3'd1);
        if (t_step < 3'd4) t_sh <= {t_sh[11:0], o_tracer_nibble};
        if (t_step == 3'd3) t_op <= {t_sh[11:0], o_tracer_nibble};
    end

    assign t_res = recip(t_op, o_tracer_abs);
    assign i_tracer_byte = t_step == 3'd5 ? t_res[15:8] : (t_step == 3'd0 ? t_res[7:0] : 8'hA5);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] op, input logic a, output int t);
        int n = 0;
        i_op_valid = 1'b1;
        i_operand  = op;
        i_abs      = a;
        while (!o_op_ready && n < 20) begin
            tick();
            n++;
        end
        chk("acc_ready", 32'(o_op_ready), 32'd1);
        tick();
        t = cyc;
        i_op_valid = 1'b0;
        i_operand  = 16'hDEAD;
        i_abs      = 1'b1;
    endtask

    task automatic wait_res(input logic [15:0] exp, input string tag, output int t);
        int n = 0;
        while (!o_res_valid && n < 30) begin
            tick();
            n++;
        end
        t = cyc;
        chk({tag, "_valid"}, 32'(o_res_valid), 32'd1);
        chk(tag, 32'(o_result), 32'(exp));
    endtask

    initial begin
        int a1, a2, r1, r2, t;
        logic seen;
        repeat (3) tick();
        chk("rst_op_ready", 32'(o_op_ready), 32'd0);
        chk("rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_tr_reset", 32'(o_tracer_reset), 32'd1);
        chk("rst_tr_abs", 32'(o_tracer_abs), 32'd0);
        chk("rst_nibble", 32'(o_tracer_nibble), 32'd0);
        reset = 1'b0;
        tick();
        chk("sync_hold1", 32'(o_tracer_reset), 32'd1);
        tick();
        chk("sync_done", 32'(o_tracer_reset), 32'd0);
        seen = 1'b0;
        for (int k = 3; k < 7; k++) begin
            tick();
            seen |= o_op_ready;
        end
        chk("ready_early", 32'(seen), 32'd0);
        tick();
        chk("ready_first", 32'(o_op_ready), 32'd1);

        accept(16'h0400, 1'b0, a1);
        chk("nib_ph0", 32'(o_tracer_nibble), 32'h0);
        tick();
        chk("nib_ph1", 32'(o_tracer_nibble), 32'h4);
        tick();
        chk("nib_ph2", 32'(o_tracer_nibble), 32'h0);
        tick();
        chk("nib_ph3", 32'(o_tracer_nibble), 32'h0);
        repeat (3) tick();
        chk("lat_not_yet", 32'(o_res_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(o_res_valid), 32'd1);
        chk("res_1p0", 32'(o_result), 32'h0400);
        i_res_ready = 1'b1;
        tick();
        chk("pop_empty", 32'(o_res_valid), 32'd0);

        accept(16'h0800, 1'b0, a1);
        accept(16'h1000, 1'b0, a2);
        chk("b2b_spacing", 32'(a2 - a1), 32'd6);
        wait_res(16'h0200, "res_2p0", r1);
        chk("latency", 32'(r1 - a1), 32'd7);
        tick();
        wait_res(16'h0100, "res_4p0", r2);
        chk("res_spacing", 32'(r2 - r1), 32'd6);
        tick();
        i_res_ready = 1'b0;

        accept(16'h0400, 1'b0, t);
        accept(16'h0200, 1'b0, t);
        i_op_valid = 1'b1;
        i_operand  = 16'h2000;
        i_abs      = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= o_op_ready;
        end
        chk("full_no_ready", 32'(seen), 32'd0);
        chk("full_head", 32'(o_result), 32'h0400);
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        chk("full_next", 32'(o_result), 32'h0800);
        accept(16'h2000, 1'b0, t);
        chk("full_keep", 32'(o_result), 32'h0800);
        i_res_ready = 1'b1;
        tick();
        chk("drain_empty", 32'(o_res_valid), 32'd0);
        chk("hold_result", 32'(o_result), 32'h0800);
        wait_res(16'h0080, "res_8p0", t);
        tick();

        accept(16'hFC00, 1'b1, a1);
        accept(16'h0800, 1'b0, a2);
        chk("abs_ph0_old", 32'(o_tracer_abs), 32'd1);
        tick();
        chk("abs_ph1_new", 32'(o_tracer_abs), 32'd0);
        chk("res_abs_valid", 32'(o_res_valid), 32'd1);
        chk("res_abs_m1", 32'(o_result), 32'h0400);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= o_tracer_abs;
        end
        chk("abs_ph2to5", 32'(seen), 32'd0);
        wait_res(16'h0200, "res_after_abs", t);
        tick();
        accept(16'hFC00, 1'b0, t);
        wait_res(16'hFC00, "res_m1", t);
        tick();

        accept(16'h0400, 1'b0, t);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_res_valid), 32'd0);
        chk("mid_rst_tr_reset", 32'(o_tracer_reset), 32'd1);
        chk("mid_rst_ready", 32'(o_op_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("resync_hold", 32'(o_tracer_reset), 32'd1);
        tick();
        chk("resync_done", 32'(o_tracer_reset), 32'd0);
        seen = 1'b0;
        repeat (14) begin
            tick();
            seen |= o_res_valid;
        end
        chk("no_stale_push", 32'(seen), 32'd0);
        accept(16'h0800, 1'b0, t);
        wait_res(16'h0200, "res_post_rst", t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
